// File: rtl/branch_inflight_tracker.sv
// branch_inflight_tracker
//   Tracks up to MAX_BR unresolved branches in a ring. Each slot has a valid
//   and a resolved bit. Branches are allocated at the tail and retired in
//   order from the head. Resolutions from the CDB may arrive out of order.
//   A mispredict kills every younger slot and rewinds the tail, and it
//   raises a one-cycle registered flush pulse with a mask of the killed slots.
//
// Ports
//   clk                clock, rising edge
//   reset              synchronous, active-low
//   Branch             decoded branch requesting issue
//   Issueque_full_int  issue queue full, branch is held off
//   cdb_branch         CDB carries a branch resolution
//   cdb_branch_tag     tag of the resolving branch
//   cdb_mispredict     resolving branch was mispredicted
//   stall              ring full, front end must stall
//   alloc_valid        branch accepted this cycle (combinational)
//   alloc_tag          tag given to the accepted branch (tail pointer)
//   inflight_count     allocated, not yet retired entries
//   flush              registered pulse the cycle after a mispredict
//   flush_mask         slots killed by that mispredict, 0 when flush=0

// Single ring slot. Clearing has priority over allocation. Allocation only
// targets a free slot, so it never collides with a retire or a kill.
module branch_inflight_slot (
    input  logic clk,
    input  logic reset,
    input  logic alloc,
    input  logic resolve,
    input  logic clear,
    output logic valid,
    output logic resolved
);
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            valid    <= 1'b0;
            resolved <= 1'b0;
        end else if (alloc) begin
            valid    <= 1'b1;
            resolved <= 1'b0;
        end else if (resolve) begin
            resolved <= 1'b1;
        end
    end
endmodule

module branch_inflight_tracker #(
    parameter int MAX_BR = 4,
    parameter int TAG_W  = 2,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Branch,
    input  logic              Issueque_full_int,
    input  logic              cdb_branch,
    input  logic [TAG_W-1:0]  cdb_branch_tag,
    input  logic              cdb_mispredict,
    output logic              stall,
    output logic              alloc_valid,
    output logic [TAG_W-1:0]  alloc_tag,
    output logic [CNT_W-1:0]  inflight_count,
    output logic              flush,
    output logic [MAX_BR-1:0] flush_mask
);
    typedef struct packed {
        logic             hit;        // resolution names a live slot
        logic             mispredict; // qualified mispredict
        logic [TAG_W-1:0] tag;
    } cdb_t;

    logic [MAX_BR-1:0] valid, resolved, kill;
    logic [MAX_BR-1:0] slot_alloc, slot_res, slot_clr;
    logic [TAG_W-1:0]  head, tail, t_off;
    logic [CNT_W-1:0]  count;
    logic              retire;
    cdb_t              cdb;

    assign cdb.hit        = cdb_branch & valid[cdb_branch_tag];
    assign cdb.mispredict = cdb.hit & cdb_mispredict;
    assign cdb.tag        = cdb_branch_tag;

    assign retire         = valid[head] & resolved[head];
    assign stall          = reset & (count == CNT_W'(MAX_BR));
    // A branch arriving with a live mispredict is younger than it, so it is
    // dropped instead of being allocated and killed.
    assign alloc_valid    = reset & Branch & ~Issueque_full_int & ~stall & ~cdb.mispredict;
    assign alloc_tag      = tail;
    assign inflight_count = count;

    // Age relative to head. Live slots are contiguous from head, so
    // "younger than T" means a larger head-relative offset.
    assign t_off = cdb.tag - head;

    for (genvar i = 0; i < MAX_BR; i++) begin : g_slot
        logic [TAG_W-1:0] off;
        assign off           = TAG_W'(i) - head;
        assign kill[i]       = cdb.mispredict & valid[i] & (off > t_off);
        assign slot_alloc[i] = alloc_valid & (tail == TAG_W'(i));
        assign slot_res[i]   = cdb.hit & (cdb.tag == TAG_W'(i));
        assign slot_clr[i]   = kill[i] | (retire & (head == TAG_W'(i)));

        branch_inflight_slot u_slot (
            .clk      (clk),
            .reset    (reset),
            .alloc    (slot_alloc[i]),
            .resolve  (slot_res[i]),
            .clear    (slot_clr[i]),
            .valid    (valid[i]),
            .resolved (resolved[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            flush      <= 1'b0;
            flush_mask <= '0;
        end else begin
            flush      <= cdb.mispredict;
            flush_mask <= kill;
            if (retire)
                head <= head + TAG_W'(1);
            if (cdb.mispredict) begin
                // Survivors are head..T inclusive. The offset is used
                // rather than tail-head, so a full ring is still counted.
                tail  <= cdb.tag + TAG_W'(1);
                count <= CNT_W'(t_off) + CNT_W'(1) - CNT_W'(retire);
            end else begin
                if (alloc_valid)
                    tail <= tail + TAG_W'(1);
                count <= count + CNT_W'(alloc_valid) - CNT_W'(retire);
            end
        end
    end
endmodule
